// File: rtl/cc1200_spi_slave_if.sv
// SPI bus between the CC1200 master and the emulated CC1200 responder.
interface cc1200_spi_slave_if;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        input  miso
    );

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        output miso
    );
endinterface

// File: rtl/cc1200_spi_slave.sv
// CC1200 register-access SPI responder: oversamples the SPI bus in the clk
// domain, decodes the header byte, serves a 48-byte register file and
// reports command strobes.
module cc1200_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    cc1200_spi_slave_if.slave   spi,
    input  logic [2:0]          status_state,
    output logic                strobe_valid,
    output logic [5:0]          strobe_cmd,
    output logic                reg_wr_valid,
    output logic [5:0]          reg_wr_addr,
    output logic [7:0]          reg_wr_data,
    input  logic [5:0]          dbg_addr,
    output logic [7:0]          dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA,
        ST_IGNORE
    } state_t;

    localparam int unsigned NUM_REGS = 48;
    localparam logic [5:0]  LAST_REG = 6'h2F;
    localparam logic [5:0]  LAST_STROBE = 6'h3D;

    // Synchronisers and edge-detect delay flops
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   cs_dly_q, cs_dly_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic byte_done;

    // Protocol state
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  tx_next_q, tx_next_d;
    logic        reload_q, reload_d;
    logic [5:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        burst_q, burst_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic [7:0]  regs_d [NUM_REGS];

    // Event reporting
    logic        wr_fire_q, wr_fire_d;
    logic        strobe_fire_q, strobe_fire_d;
    logic        reg_wr_valid_q, reg_wr_valid_d;
    logic [5:0]  reg_wr_addr_q, reg_wr_addr_d;
    logic [7:0]  reg_wr_data_q, reg_wr_data_d;
    logic        strobe_valid_q, strobe_valid_d;
    logic [5:0]  strobe_cmd_q, strobe_cmd_d;

    logic [7:0]  rx_byte;
    logic [5:0]  addr_next;

    // Synchroniser shift and edge detection
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_dly_d  = sclk_s;
        cs_dly_d    = cs_s;
        sclk_rise   = sclk_s & ~sclk_dly_q;
        sclk_fall   = ~sclk_s & sclk_dly_q;
        cs_rise     = cs_s & ~cs_dly_q;
        cs_fall     = ~cs_s & cs_dly_q;
        byte_done   = sclk_rise && (bit_cnt_q == 3'd7);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a chip-select rise overrides any byte completing in the same cycle
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (cs_fall) state_d = ST_HEADER;
                ST_HEADER: if (byte_done) state_d = (rx_byte[5:0] <= LAST_REG) ? ST_DATA : ST_IGNORE;
                ST_DATA:   if (byte_done && !burst_q) state_d = ST_IGNORE;
                ST_IGNORE: state_d = ST_IGNORE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: MISO is only driven while selected
    always_comb begin
        spi.miso = (state_q != ST_IDLE) ? tx_q[7] : 1'b0;
    end

    // Shift registers, header decode, register file and event staging
    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        rx_d           = rx_q;
        tx_d           = tx_q;
        tx_next_d      = tx_next_q;
        reload_d       = reload_q;
        addr_d         = addr_q;
        rw_d           = rw_q;
        burst_d        = burst_q;
        regs_d         = regs_q;
        wr_fire_d      = 1'b0;
        strobe_fire_d  = 1'b0;
        reg_wr_valid_d = wr_fire_q;
        strobe_valid_d = strobe_fire_q;
        reg_wr_addr_d  = reg_wr_addr_q;
        reg_wr_data_d  = reg_wr_data_q;
        strobe_cmd_d   = strobe_cmd_q;
        rx_byte        = {rx_q[6:0], mosi_s};
        addr_next      = (addr_q == LAST_REG) ? 6'h00 : addr_q + 6'd1;

        if (state_q == ST_IDLE) begin
            if (cs_fall) begin
                bit_cnt_d = '0;
                tx_d      = {1'b0, status_state, 4'b0000};
                tx_next_d = '0;
                reload_d  = 1'b0;
            end
        end else if (!cs_rise) begin
            if (sclk_rise) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    reload_d  = 1'b1;
                    tx_next_d = '0;
                    unique case (state_q)
                        ST_HEADER: begin
                            rw_d    = rx_byte[7];
                            burst_d = rx_byte[6];
                            addr_d  = rx_byte[5:0];
                            if (rx_byte[5:0] <= LAST_REG) begin
                                if (rx_byte[7]) tx_next_d = regs_q[rx_byte[5:0]];
                            end else if (rx_byte[5:0] <= LAST_STROBE) begin
                                strobe_fire_d = 1'b1;
                                strobe_cmd_d  = rx_byte[5:0];
                            end
                        end
                        ST_DATA: begin
                            if (!rw_q) begin
                                regs_d[addr_q] = rx_byte;
                                wr_fire_d      = 1'b1;
                                reg_wr_addr_d  = addr_q;
                                reg_wr_data_d  = rx_byte;
                            end
                            if (burst_q) begin
                                addr_d = addr_next;
                                // read from regs_d so a same-cycle write is visible
                                if (rw_q) tx_next_d = regs_d[addr_next];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            if (sclk_fall) begin
                if (reload_q) begin
                    tx_d     = tx_next_q;
                    reload_d = 1'b0;
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end
    end

    // Debug read port
    always_comb begin
        dbg_data = 8'h00;
        if (dbg_addr <= LAST_REG) dbg_data = regs_q[dbg_addr];
    end

    // Datapath and synchroniser registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q    <= '0;
            cs_sync_q      <= '1;
            mosi_sync_q    <= '0;
            sclk_dly_q     <= 1'b0;
            cs_dly_q       <= 1'b1;
            bit_cnt_q      <= '0;
            rx_q           <= '0;
            tx_q           <= '0;
            tx_next_q      <= '0;
            reload_q       <= 1'b0;
            addr_q         <= '0;
            rw_q           <= 1'b0;
            burst_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_fire_q      <= 1'b0;
            strobe_fire_q  <= 1'b0;
            reg_wr_valid_q <= 1'b0;
            reg_wr_addr_q  <= '0;
            reg_wr_data_q  <= '0;
            strobe_valid_q <= 1'b0;
            strobe_cmd_q   <= '0;
        end else begin
            sclk_sync_q    <= sclk_sync_d;
            cs_sync_q      <= cs_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            sclk_dly_q     <= sclk_dly_d;
            cs_dly_q       <= cs_dly_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_q           <= rx_d;
            tx_q           <= tx_d;
            tx_next_q      <= tx_next_d;
            reload_q       <= reload_d;
            addr_q         <= addr_d;
            rw_q           <= rw_d;
            burst_q        <= burst_d;
            regs_q         <= regs_d;
            wr_fire_q      <= wr_fire_d;
            strobe_fire_q  <= strobe_fire_d;
            reg_wr_valid_q <= reg_wr_valid_d;
            reg_wr_addr_q  <= reg_wr_addr_d;
            reg_wr_data_q  <= reg_wr_data_d;
            strobe_valid_q <= strobe_valid_d;
            strobe_cmd_q   <= strobe_cmd_d;
        end
    end

    assign strobe_valid = strobe_valid_q;
    assign strobe_cmd   = strobe_cmd_q;
    assign reg_wr_valid = reg_wr_valid_q;
    assign reg_wr_addr  = reg_wr_addr_q;
    assign reg_wr_data  = reg_wr_data_q;

endmodule

// File: tb/tb_cc1200_spi_slave.sv
// Testbench for cc1200_spi_slave: bit-banged SPI master, transaction-level
// reference model of the CC1200 register protocol, directed and random traffic.
module tb_cc1200_spi_slave;

    localparam int H = 6;   // clk cycles per SCLK half period

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] status_state;
    logic       strobe_valid;
    logic [5:0] strobe_cmd;
    logic       reg_wr_valid;
    logic [5:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [5:0] dbg_addr;
    logic [7:0] dbg_data;

    cc1200_spi_slave_if spi ();

    cc1200_spi_slave #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi),
        .status_state (status_state),
        .strobe_valid (strobe_valid),
        .strobe_cmd   (strobe_cmd),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // reference model state and expectations
    logic [7:0]  mregs [48];
    logic [7:0]  tx_bytes [5];
    logic [7:0]  rx_bytes [5];
    logic [7:0]  exp_miso [5];
    int          n_bytes;
    logic [13:0] exp_wr_q[$];
    logic [5:0]  exp_st_q[$];

    // observed event pulses
    logic [13:0] got_wr_q[$];
    logic [5:0]  got_st_q[$];

    always @(negedge clk) begin
        if (reg_wr_valid) got_wr_q.push_back({reg_wr_addr, reg_wr_data});
        if (strobe_valid) got_st_q.push_back(strobe_cmd);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 bit transfer; optionally raises CS_n together with the last rise
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit cs_on_last,
                            output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = mo[7-i];
            wait_clk(H);
            mi[7-i] = spi.miso;
            spi.sclk = 1'b1;
            if (cs_on_last && i == nbits - 1) spi.cs_n = 1'b1;
            wait_clk(H);
            spi.sclk = 1'b0;
        end
    endtask

    // Protocol model: header decides target, data bytes are served per the CC1200 rules
    task automatic model_txn(input logic [2:0] st);
        logic [7:0] h;
        int a;
        h = tx_bytes[0];
        a = int'(h[5:0]);
        exp_wr_q.delete();
        exp_st_q.delete();
        exp_miso[0] = {1'b0, st, 4'b0000};
        for (int k = 1; k < 5; k++) exp_miso[k] = 8'h00;
        if (a < 48) begin
            for (int k = 1; k < n_bytes; k++) begin
                if (!h[6] && k > 1) break;
                if (h[7]) exp_miso[k] = mregs[a];
                else begin
                    mregs[a] = tx_bytes[k];
                    exp_wr_q.push_back({6'(a), tx_bytes[k]});
                end
                a = (a + 1) % 48;
            end
        end else if (a <= 'h3D) begin
            exp_st_q.push_back(h[5:0]);
        end
    endtask

    task automatic do_txn(input logic [2:0] st);
        got_wr_q.delete();
        got_st_q.delete();
        status_state = st;
        wait_clk(1);
        spi.cs_n = 1'b0;
        wait_clk(H);
        status_state = ~st;   // later changes must not reach the status byte
        for (int b = 0; b < n_bytes; b++) spi_xfer(tx_bytes[b], 8, 1'b0, rx_bytes[b]);
        wait_clk(H);
        spi.cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic check_txn(input string tag);
        for (int b = 0; b < n_bytes; b++)
            chk($sformatf("%s miso[%0d]", tag, b), 32'(rx_bytes[b]), 32'(exp_miso[b]));
        chk({tag, " wr_count"}, got_wr_q.size(), exp_wr_q.size());
        for (int i = 0; i < exp_wr_q.size() && i < got_wr_q.size(); i++)
            chk($sformatf("%s wr[%0d]", tag, i), 32'(got_wr_q[i]), 32'(exp_wr_q[i]));
        chk({tag, " strobe_count"}, got_st_q.size(), exp_st_q.size());
        for (int i = 0; i < exp_st_q.size() && i < got_st_q.size(); i++)
            chk($sformatf("%s strobe[%0d]", tag, i), 32'(got_st_q[i]), 32'(exp_st_q[i]));
    endtask

    task automatic run(input string tag, input logic [2:0] st, input int n,
                       input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3);
        n_bytes = n;
        tx_bytes[0] = b0; tx_bytes[1] = b1; tx_bytes[2] = b2; tx_bytes[3] = b3;
        tx_bytes[4] = 8'h00;
        model_txn(st);
        do_txn(st);
        check_txn(tag);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) begin
            dbg_addr = 6'(a);
            #1;
            chk($sformatf("%s dbg[%0h]", tag, a), 32'(dbg_data), (a < 48) ? 32'(mregs[a]) : 32'h0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " miso"},         32'(spi.miso),     32'h0);
        chk({tag, " strobe_valid"}, 32'(strobe_valid), 32'h0);
        chk({tag, " strobe_cmd"},   32'(strobe_cmd),   32'h0);
        chk({tag, " reg_wr_valid"}, 32'(reg_wr_valid), 32'h0);
        chk({tag, " reg_wr_addr"},  32'(reg_wr_addr),  32'h0);
        chk({tag, " reg_wr_data"},  32'(reg_wr_data),  32'h0);
    endtask

    initial begin
        logic [7:0] junk;
        logic [7:0] hdr;
        rst = 1'b1;
        spi.sclk = 1'b0;
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        status_state = 3'b000;
        dbg_addr = '0;
        for (int i = 0; i < 48; i++) mregs[i] = 8'h00;
        wait_clk(4);
        check_outputs_zero("reset");
        rst = 1'b0;
        wait_clk(6);

        // single write with status byte
        run("wr_single", 3'b010, 2, 8'h05, 8'hA5, 8'h00, 8'h00);
        dbg_addr = 6'h05; #1;
        chk("dbg_0x05", 32'(dbg_data), 32'h0000_00A5);

        // burst write wrapping past 0x2F, then burst read back
        run("wr_burst_wrap", 3'b101, 4, 8'h6E, 8'h11, 8'h22, 8'h33);
        run("rd_burst_wrap", 3'b011, 4, 8'hEE, 8'h00, 8'h00, 8'h00);

        // non-burst read followed by an ignored byte
        run("rd_single", 3'b001, 3, 8'h85, 8'h00, 8'h00, 8'h00);

        // strobe with trailing byte, and unsupported addresses
        run("strobe_36", 3'b111, 2, 8'h36, 8'hFF, 8'h00, 8'h00);
        chk("strobe_cmd_hold", 32'(strobe_cmd), 32'h36);
        run("strobe_3d", 3'b100, 1, 8'hFD, 8'h00, 8'h00, 8'h00);
        run("unsupported_3e", 3'b110, 2, 8'h3E, 8'h55, 8'h00, 8'h00);
        run("unsupported_3f", 3'b000, 2, 8'hFF, 8'h00, 8'h00, 8'h00);

        // abort after 5 data bits
        got_wr_q.delete();
        spi.cs_n = 1'b0;
        wait_clk(H);
        spi_xfer(8'h07, 8, 1'b0, junk);
        spi_xfer(8'hFF, 5, 1'b0, junk);
        wait_clk(H);
        spi.cs_n = 1'b1;
        wait_clk(12);
        chk("abort wr_count", got_wr_q.size(), 0);
        dbg_addr = 6'h07; #1;
        chk("abort dbg_0x07", 32'(dbg_data), 32'h0);

        // CS_n rise coincident with the 8th data rise discards the byte
        got_wr_q.delete();
        spi.cs_n = 1'b0;
        wait_clk(H);
        spi_xfer(8'h09, 8, 1'b0, junk);
        spi_xfer(8'hC3, 8, 1'b1, junk);
        wait_clk(12);
        chk("cs_vs_8th wr_count", got_wr_q.size(), 0);
        dbg_addr = 6'h09; #1;
        chk("cs_vs_8th dbg_0x09", 32'(dbg_data), 32'h0);

        sweep("directed");

        // randomized traffic against the model
        for (int t = 0; t < 24; t++) begin
            hdr = 8'($urandom);
            if ($urandom_range(0, 3) != 0) hdr[5:0] = 6'($urandom_range(0, 47));
            run($sformatf("rand%0d", t), 3'($urandom), $urandom_range(1, 5),
                hdr, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        sweep("random");

        // reset in the middle of a burst write
        spi.cs_n = 1'b0;
        wait_clk(H);
        spi_xfer(8'h40, 8, 1'b0, junk);
        spi_xfer(8'h11, 8, 1'b0, junk);
        spi_xfer(8'h22, 8, 1'b0, junk);
        spi_xfer(8'h33, 3, 1'b0, junk);
        rst = 1'b1;
        for (int i = 0; i < 48; i++) mregs[i] = 8'h00;
        wait_clk(2);
        check_outputs_zero("mid_reset");
        spi.cs_n = 1'b1;
        spi.sclk = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);
        sweep("after_reset");
        run("post_reset_wr", 3'b010, 2, 8'h05, 8'h5A, 8'h00, 8'h00);
        run("post_reset_rd", 3'b110, 2, 8'h85, 8'h00, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/cc1200_spi_slave.md
# cc1200_spi_slave

SPI responder emulating the CC1200 register-access protocol: the far end of the team's CC1200 SPI master. It oversamples SCLK/CS_n/MOSI in the system clock domain and decodes the CC1200 header byte (R/W, burst, 6-bit address). It serves reads and writes to a 48-byte register file and reports command strobes, so the master and its APB driver can be exercised in closed loop in simulation and on FPGA.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `sclk`, `cs_n` and `mosi` before edge detection (minimum 2).
- `clk` input 1: system clock, the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `sclk` input 1: SPI clock from the master, asynchronous to `clk`. Mode 0.
- `cs_n` input 1: chip select, active low, asynchronous.
- `mosi` input 1: master-out data, MSB first.
- `miso` output 1: slave-out data, MSB first. Forced 0 while deselected.
- `status_state` input 3: chip-state field returned in the status byte.
- `strobe_valid` output 1: one-`clk` pulse when a strobe header is decoded.
- `strobe_cmd` output 6: strobe address, 0x30–0x3D. Held until the next strobe.
- `reg_wr_valid` output 1: one-`clk` pulse on each committed register write.
- `reg_wr_addr` output 6: address of the committed write.
- `reg_wr_data` output 8: data of the committed write.
- `dbg_addr` input 6: debug read address.
- `dbg_data` output 8: combinational read of `regs[dbg_addr]`. Returns 0x00 for addresses ≥ 0x30.

## Operation
- **Synchronisers:** `sclk`, `cs_n` and `mosi` each pass through `SYNC_STAGES` FFs. Rising and falling edges of synced `sclk` and `cs_n` are detected against one extra FF.
- **State machine:** IDLE, HEADER, DATA, IGNORE.
- **IDLE:** `miso`=0. On a synced `cs_n` fall: bit counter cleared, TX shift register loaded with the status byte `{1'b0, status_state, 4'b0000}`, go to HEADER.
- **Bit timing:**
  - On each synced `sclk` rise: sample synced `mosi` into the RX shift register and increment the 3-bit bit counter.
  - On each synced `sclk` fall: shift TX left. If a reload is pending, load `tx_next` instead of shifting.
  - `miso` = TX[7].
- **Header decode** (8th rise in HEADER): rw = bit7, burst = bit6, addr = bits5:0.
  - addr ≤ 0x2F, read: `tx_next` = `regs[addr]`, go to DATA.
  - addr ≤ 0x2F, write: `tx_next` = 0x00, go to DATA.
  - addr 0x30–0x3D: `strobe_valid` pulse, `strobe_cmd` = addr, `tx_next` = 0x00, go to IGNORE. rw and burst are ignored.
  - addr 0x3E/0x3F: not supported; go to IGNORE with no strobe.
- **DATA, 8th rise of each byte:**
  - Write: `regs[addr]` ← RX byte, and `reg_wr_valid`/`reg_wr_addr`/`reg_wr_data` asserted the next `clk`.
  - Burst: addr increments, wrapping 0x2F → 0x00. For reads, `tx_next` = `regs[new addr]`, fetched after any write in the same cycle.
  - Non-burst: after the first data byte, go to IGNORE.
- **IGNORE:** bytes are clocked but discarded; `tx_next` = 0x00.
- **Any state, synced `cs_n` rise:** go to IDLE. A partial byte is discarded, with no write and no strobe.
- **Register file:** 48 × 8, all entries reset to 0x00.

## Timing
- **Reset values:**
  - `miso`, `strobe_valid`, `reg_wr_valid` = 0.
  - `strobe_cmd`, `reg_wr_addr`, `reg_wr_data` = 0.
  - State = IDLE.
- **SCLK constraint:** each SCLK high and low phase must be ≥ `SYNC_STAGES`+2 `clk` periods (≥ 4 at default). CS_n setup to the first SCLK rise must also be ≥ 4 `clk` periods.
- **MISO latency:** `miso` changes `SYNC_STAGES`+1 `clk` after the external SCLK fall. The master samples on the rise, so the margin is half a period minus this latency.
- **Write latency:** `reg_wr_valid` asserts `SYNC_STAGES`+2 `clk` after the external 8th SCLK rise of the data byte.
- **Strobe latency:** same as the write latency, counted from the 8th header rise.
- **Debug read:** `dbg_data` reflects a write on the `clk` after the `regs` update.
- **`status_state` capture:** sampled once, at the CS_n-fall detect; later changes do not affect the byte in flight.
- **Simultaneous CS_n rise and 8th SCLK rise** (same `clk` after sync): CS_n wins and the byte is discarded.
- **Reset mid-transaction:** immediate return to IDLE. The register file clears and no pulses are issued.

## Test plan
- **Single write + status:** with `status_state`=3'b010, send header 0x05 then data 0xA5.
  - MISO during the header = 0x20.
  - `reg_wr_valid` pulses once with addr 0x05, data 0xA5.
  - `dbg_data` @0x05 = 0xA5.
- **Burst write with wrap:** header 0x6E, data 0x11, 0x22, 0x33.
  - `regs[0x2E]`=0x11, `regs[0x2F]`=0x22, `regs[0x00]`=0x33.
  - Exactly three `reg_wr_valid` pulses.
- **Burst read:** after the previous test, header 0xEE with three dummy bytes → MISO bytes = status, 0x11, 0x22, 0x33.
- **Non-burst read then extra byte:** header 0x85 with two dummy bytes → MISO = status, 0xA5, 0x00. No writes.
- **Strobe:** header 0x36 plus one extra byte 0xFF.
  - One `strobe_valid` pulse, `strobe_cmd`=0x36.
  - No `reg_wr_valid`.
  - MISO on the second byte = 0x00.
- **Abort and reset:**
  - Header 0x07, then CS_n rises after 5 data bits → no write; `regs[0x07]` stays 0x00.
  - Assert `rst` mid-burst-write → all outputs 0, all regs 0x00.
  - The next transaction decodes normally.
